// File: rtl/bus_sched.sv
// bus_sched: round-robin shared-bus scheduler that sequences emitter and snooper CPUs
module bus_sched #(
    parameter  int NPROC = 4,
    parameter  int BUSW  = 10,
    localparam int GW    = $clog2(NPROC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NPROC-1:0]      req,
    input  logic [NPROC*BUSW-1:0] cpu_bus_out,
    input  logic [NPROC-1:0]      cpu_shared_out,
    output logic [NPROC-1:0]      controleP,
    output logic [NPROC-1:0]      habilita,
    output logic [NPROC-1:0]      cpu_clear,
    output logic [BUSW-1:0]       bus_in,
    output logic [NPROC-1:0]      shared_in,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, CLR, ISSUE, LATCH, SNOOP, RESP} state_t;
    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [GW-1:0]    rr_q, rr_d, grant_q, grant_d, win;
    logic [NPROC-1:0] ctrl_q, ctrl_d, shared_q, shared_d;
    logic [BUSW-1:0]  bus_q, bus_d;
    logic             found;

    // first requester at or after the round-robin pointer, wrapping at NPROC
    always_comb begin
        int idx;
        logic [GW-1:0] cand;
        win = '0;
        found = 1'b0;
        idx = 0;
        cand = '0;
        for (int k = 0; k < NPROC; k++) begin
            idx = int'(rr_q) + k;
            cand = GW'(idx >= NPROC ? idx - NPROC : idx);
            if (!found && req[cand]) begin
                win = cand;
                found = 1'b1;
            end
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            grant_q  <= '0;
            ctrl_q   <= '0;
            bus_q    <= '0;
            shared_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            ctrl_q   <= ctrl_d;
            bus_q    <= bus_d;
            shared_q <= shared_d;
        end
    end

    // transaction sequencing: grant, clear, issue, latch, snoop, respond
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        ctrl_d   = ctrl_q;
        bus_d    = bus_q;
        shared_d = shared_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = CLR;
                grant_d = win;
                ctrl_d  = NPROC'(1) << win;
                rr_d    = win == GW'(NPROC - 1) ? '0 : win + 1'b1;
            end
            CLR: begin
                state_d  = ISSUE;
                cnt_d    = '0;
                shared_d = '0;
            end
            ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) state_d = LATCH;
            end
            LATCH: begin
                state_d = SNOOP;
                cnt_d   = '0;
                bus_d   = cpu_bus_out[grant_q*BUSW +: BUSW];
            end
            SNOOP: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) state_d = RESP;
            end
            RESP: begin
                state_d  = IDLE;
                shared_d = |(cpu_shared_out & ~ctrl_q) ? ctrl_q : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // strobes decoded from state and the held emitter select only
    always_comb begin
        habilita  = state_q == ISSUE ? ctrl_q : state_q == SNOOP ? ~ctrl_q : '0;
        cpu_clear = {NPROC{state_q == CLR}};
        done      = state_q == RESP;
        busy      = state_q != IDLE;
    end

    assign controleP = ctrl_q;
    assign bus_in    = bus_q;
    assign shared_in = shared_q;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_bus_sched.sv
// tb_bus_sched: directed scenarios plus randomized run against a transaction-level model
module tb_bus_sched;
    localparam int NPROC = 4;
    localparam int BUSW  = 10;
    localparam int GW    = 2;
    localparam int CW    = NPROC * BUSW;

    logic             clock, clear, busy, done;
    logic [NPROC-1:0] req, cpu_shared_out, controleP, habilita, cpu_clear, shared_in;
    logic [CW-1:0]    cpu_bus_out;
    logic [BUSW-1:0]  bus_in;
    logic [GW-1:0]    grant_id;
    int vectors = 0;
    int miscompares = 0;

    bus_sched #(.NPROC(NPROC), .BUSW(BUSW)) dut (
        .clock(clock), .clear(clear), .req(req), .cpu_bus_out(cpu_bus_out),
        .cpu_shared_out(cpu_shared_out), .controleP(controleP), .habilita(habilita),
        .cpu_clear(cpu_clear), .bus_in(bus_in), .shared_in(shared_in),
        .grant_id(grant_id), .busy(busy), .done(done)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        clear = 1;
        req = '0;
        @(negedge clock);
        clear = 0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        clear = 1;
        repeat (3) begin
            req = NPROC'($urandom);
            cpu_bus_out = CW'({$urandom, $urandom});
            cpu_shared_out = NPROC'($urandom);
            @(negedge clock);
            vectors++;
            if ({controleP, habilita, cpu_clear, bus_in, shared_in, grant_id, busy, done} !== '0) begin
                miscompares++;
                $display("FAIL reset outputs: got %h expected 0", {controleP, habilita, cpu_clear, bus_in, shared_in, grant_id, busy, done});
            end
        end
        clear = 0;
        req = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            vectors++;
            if ({busy, done, habilita, cpu_clear} !== '0) begin
                miscompares++;
                $display("FAIL idle strobes cycle %0d: got %b expected 0", t, {busy, done, habilita, cpu_clear});
            end
        end
    endtask

    task automatic test_single();
        logic [NPROC-1:0] eh;
        logic [BUSW-1:0]  eb;
        eb = '0;
        do_reset();
        req = 4'b0100;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clock);
            if (t == 1) req = '0;
            eh = (t >= 2 && t <= 4) ? 4'b0100 : (t == 6 || t == 7) ? 4'b1011 : 4'b0000;
            vectors++;
            if (habilita !== eh) begin
                miscompares++;
                $display("FAIL single habilita t=%0d: got %b expected %b", t, habilita, eh);
            end
            vectors++;
            if (cpu_clear !== {NPROC{t == 1}}) begin
                miscompares++;
                $display("FAIL single cpu_clear t=%0d: got %b expected %b", t, cpu_clear, {NPROC{t == 1}});
            end
            vectors++;
            if ({done, busy} !== {t == 8, t <= 8}) begin
                miscompares++;
                $display("FAIL single done/busy t=%0d: got %b expected %b", t, {done, busy}, {t == 8, t <= 8});
            end
            vectors++;
            if ({grant_id, controleP} !== {2'd2, 4'b0100}) begin
                miscompares++;
                $display("FAIL single grant t=%0d: got %0d/%b expected 2/0100", t, grant_id, controleP);
            end
            vectors++;
            if (bus_in !== (t >= 6 ? eb : '0)) begin
                miscompares++;
                $display("FAIL single bus_in t=%0d: got %h expected %h", t, bus_in, t >= 6 ? eb : '0);
            end
            cpu_bus_out = CW'({$urandom, $urandom});
            if (t == 5) eb = cpu_bus_out[2*BUSW +: BUSW];
        end
    endtask

    task automatic test_round_robin();
        int exp_g [7] = '{0, 1, 2, 3, 0, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 7; n++) begin
            for (int t = 1; t <= 9; t++) begin
                @(negedge clock);
                if (t == 1) begin
                    vectors++;
                    if (grant_id !== GW'(exp_g[n]) || controleP !== (NPROC'(1) << exp_g[n])) begin
                        miscompares++;
                        $display("FAIL rr grant %0d: got %0d/%b expected %0d", n, grant_id, controleP, exp_g[n]);
                    end
                end
                vectors++;
                if (done !== (t == 8)) begin
                    miscompares++;
                    $display("FAIL rr done n=%0d t=%0d: got %b expected %b", n, t, done, t == 8);
                end
                if (n == 4 && t == 8) req = 4'b1001;
            end
        end
        req = '0;
    endtask

    task automatic test_shared();
        logic [NPROC-1:0] so [2] = '{4'b0010, 4'b1010};
        logic [NPROC-1:0] es [2] = '{4'b0000, 4'b0010};
        do_reset();
        for (int c = 0; c < 2; c++) begin
            req = 4'b0010;
            for (int t = 1; t <= 9; t++) begin
                @(negedge clock);
                if (t == 1) req = '0;
                cpu_shared_out = t == 8 ? so[c] : NPROC'($urandom);
                if (t == 9) begin
                    vectors++;
                    if (shared_in !== es[c]) begin
                        miscompares++;
                        $display("FAIL shared case %0d: got %b expected %b", c, shared_in, es[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NPROC-1:0] eh;
        do_reset();
        req = 4'b0100;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clock);
            if (t == 1) req = '0;
        end
        vectors++;
        if (habilita !== 4'b0100) begin
            miscompares++;
            $display("FAIL midreset pre habilita: got %b expected 0100", habilita);
        end
        clear = 1;
        #1;
        vectors++;
        if ({controleP, habilita, cpu_clear, bus_in, shared_in, grant_id, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL midreset outputs: got %h expected 0", {controleP, habilita, cpu_clear, bus_in, shared_in, grant_id, busy, done});
        end
        @(negedge clock);
        clear = 0;
        req = 4'b1111;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clock);
            if (t == 1) req = '0;
            eh = (t >= 2 && t <= 4) ? 4'b0001 : (t == 6 || t == 7) ? 4'b1110 : 4'b0000;
            vectors++;
            if ({grant_id, habilita, done} !== {2'd0, eh, t == 8}) begin
                miscompares++;
                $display("FAIL midreset seq t=%0d: got %0d/%b/%b expected 0/%b/%b", t, grant_id, habilita, done, eh, t == 8);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0010;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clock);
            if (t == 2) req = '0;
            vectors++;
            if ({done, busy, grant_id} !== {t == 8, t <= 8, 2'd1}) begin
                miscompares++;
                $display("FAIL reqdrop t=%0d: got %b expected %b", t, {done, busy, grant_id}, {t == 8, t <= 8, 2'd1});
            end
        end
    endtask

    task automatic test_random();
        int mt, mrr, mg, rq;
        logic mgv;
        logic [BUSW-1:0]  mbus;
        logic [NPROC-1:0] msh, oh, eh;
        do_reset();
        mt = 0; mrr = 0; mg = 0; mgv = 0; mbus = '0; msh = '0;
        for (int i = 0; i < 3000; i++) begin
            clear = $urandom_range(0, 199) == 0;
            req = $urandom_range(0, 2) == 0 ? '0 : NPROC'($urandom);
            cpu_bus_out = CW'({$urandom, $urandom});
            cpu_shared_out = NPROC'($urandom);
            if (clear) begin
                mt = 0; mrr = 0; mg = 0; mgv = 0; mbus = '0; msh = '0;
            end
            @(posedge clock);
            if (!clear) begin
                if (mt == 0) begin
                    rq = int'(req);
                    if (rq != 0) begin
                        for (int k = NPROC - 1; k >= 0; k--)
                            if (((rq >> ((mrr + k) % NPROC)) & 1) == 1) mg = (mrr + k) % NPROC;
                        mrr = (mg + 1) % NPROC;
                        mgv = 1;
                        mt = 1;
                    end
                end else begin
                    if (mt == 1) msh = '0;
                    if (mt == 5) mbus = BUSW'(cpu_bus_out >> (mg * BUSW));
                    if (mt == 8) msh = (cpu_shared_out & ~(NPROC'(1) << mg)) != '0 ? NPROC'(1) << mg : '0;
                    mt = mt == 8 ? 0 : mt + 1;
                end
            end
            @(negedge clock);
            oh = NPROC'(1) << mg;
            eh = (mt >= 2 && mt <= 4) ? oh : (mt == 6 || mt == 7) ? ~oh : '0;
            vectors++;
            if (controleP !== (mgv ? oh : '0)) begin
                miscompares++;
                $display("FAIL rand controleP cyc %0d: got %b expected %b", i, controleP, mgv ? oh : '0);
            end
            vectors++;
            if (habilita !== eh) begin
                miscompares++;
                $display("FAIL rand habilita cyc %0d: got %b expected %b", i, habilita, eh);
            end
            vectors++;
            if (cpu_clear !== {NPROC{mt == 1}}) begin
                miscompares++;
                $display("FAIL rand cpu_clear cyc %0d: got %b expected %b", i, cpu_clear, {NPROC{mt == 1}});
            end
            vectors++;
            if (bus_in !== mbus) begin
                miscompares++;
                $display("FAIL rand bus_in cyc %0d: got %h expected %h", i, bus_in, mbus);
            end
            vectors++;
            if (shared_in !== msh) begin
                miscompares++;
                $display("FAIL rand shared_in cyc %0d: got %b expected %b", i, shared_in, msh);
            end
            vectors++;
            if (grant_id !== GW'(mg)) begin
                miscompares++;
                $display("FAIL rand grant_id cyc %0d: got %0d expected %0d", i, grant_id, mg);
            end
            vectors++;
            if ({busy, done} !== {mt != 0, mt == 8}) begin
                miscompares++;
                $display("FAIL rand busy/done cyc %0d: got %b expected %b", i, {busy, done}, {mt != 0, mt == 8});
            end
        end
        clear = 0;
    endtask

    initial begin
        clear = 1;
        req = '0;
        cpu_bus_out = '0;
        cpu_shared_out = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_shared();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
